// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer.
// Holds the duty (percent) and frequency (Hz) settings, steps them on key
// presses, and derives the generator's period/high-time counts with one
// shared multi-cycle divider/multiplier. New counts reach the generator
// only on a PWM period boundary, so it never sees a half-updated pair.
//
// Handshake: press_duty, press_freq and period_end are single-cycle
// strobes with no back-pressure. Every press is accepted: it updates the
// setting on that edge, and if a computation is already running it is
// remembered as "pending" so a single recompute follows. cfg_valid is a
// one-cycle strobe marking the cycle in which period/htime show new
// values; the generator has no ready and must take them then.
//
// The FSM state is kept in the named signal `state` so checkers can bind
// to it directly.
module pwm_cfg_sequencer #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DUTY_INIT = 99,
    parameter int unsigned DUTY_STEP = 2,
    parameter int unsigned FREQ_INIT = 200,
    parameter int unsigned FREQ_STEP = 4,
    parameter int unsigned FREQ_MIN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        press_duty,
    input  logic        press_freq,
    input  logic        period_end,
    output logic [7:0]  duty,
    output logic [8:0]  frequency,
    output logic [23:0] period,
    output logic [23:0] htime,
    output logic        cfg_valid,
    output logic        busy
);

    // Sized copies of the parameters so every compare/assign is width-exact.
    localparam logic [31:0] CLK_HZ_W     = 32'(CLK_HZ);
    localparam logic [7:0]  DUTY_INIT_W  = 8'(DUTY_INIT);
    localparam logic [7:0]  DUTY_STEP_W  = 8'(DUTY_STEP);
    localparam logic [7:0]  DUTY_WRAP_W  = 8'(DUTY_STEP + 1);
    localparam logic [8:0]  FREQ_INIT_W  = 9'(FREQ_INIT);
    localparam logic [8:0]  FREQ_STEP_W  = 9'(FREQ_STEP);
    localparam logic [8:0]  FREQ_WRAP_W  = 9'(FREQ_MIN + FREQ_STEP);

    // Reset-time counts are worked out at elaboration, not by the datapath.
    localparam longint unsigned PERIOD_RST_L = longint'(CLK_HZ) / longint'(FREQ_INIT);
    localparam longint unsigned HTIME_RST_L  = (PERIOD_RST_L * longint'(DUTY_INIT)) / 64'd100;
    localparam logic [23:0]     PERIOD_RST   = 24'(PERIOD_RST_L);
    localparam logic [23:0]     HTIME_RST    = 24'(HTIME_RST_L);

    typedef enum logic [2:0] {
        IDLE,
        DIV_P,
        MUL_H,
        DIV_H,
        WAIT_EDGE,
        COMMIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        any_press;
    logic [7:0]  duty_next;
    logic [8:0]  freq_next;
    logic        pending;
    logic        start_calc;
    logic        commit_now;

    // Shared datapath registers. In a divide, a_reg holds dividend bits
    // being shifted out while quotient bits shift in, b_reg holds the
    // divisor, r_reg the partial remainder. In the multiply, a_reg is the
    // multiplier (shifted right), b_reg the multiplicand (shifted left)
    // and r_reg the running product.
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] r_reg;
    logic [4:0]  cnt;
    logic [7:0]  duty_snap;
    logic [23:0] p_calc;
    logic [23:0] h_calc;

    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        q_bit;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] mul_acc;

    assign any_press = press_duty | press_freq;

    // Stepped settings; wrap to the initial value before leaving the legal range.
    always_comb begin
        duty_next = duty;
        freq_next = frequency;
        if (press_duty) begin
            duty_next = (duty < DUTY_WRAP_W) ? DUTY_INIT_W : duty - DUTY_STEP_W;
        end
        if (press_freq) begin
            freq_next = (frequency < FREQ_WRAP_W) ? FREQ_INIT_W : frequency - FREQ_STEP_W;
        end
    end

    // One restoring-divide step and one shift-add step, shared by all states.
    always_comb begin
        rem_sh   = {r_reg, a_reg[31]};
        rem_diff = rem_sh - {1'b0, b_reg};
        q_bit    = ~rem_diff[32];
        div_r    = q_bit ? rem_diff[31:0] : rem_sh[31:0];
        div_q    = {a_reg[30:0], q_bit};
        mul_acc  = a_reg[0] ? (r_reg + b_reg) : r_reg;
    end

    // Settings register: updates on every press regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            duty      <= DUTY_INIT_W;
            frequency <= FREQ_INIT_W;
        end else begin
            duty      <= duty_next;
            frequency <= freq_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and decoded outputs.
    always_comb begin
        state_next = state;
        start_calc = 1'b0;
        commit_now = 1'b0;
        case (state)
            IDLE: begin
                if (any_press) begin
                    state_next = DIV_P;
                    start_calc = 1'b1;
                end
            end
            DIV_P: begin
                if (cnt == 5'd31) state_next = MUL_H;
            end
            MUL_H: begin
                if (cnt == 5'd7) state_next = DIV_H;
            end
            DIV_H: begin
                if (cnt == 5'd31) state_next = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (period_end) begin
                    state_next = COMMIT;
                    commit_now = 1'b1;
                end
            end
            COMMIT: begin
                // A press landing in this very cycle is folded into the
                // recompute started here instead of being left pending.
                if (pending || any_press) begin
                    state_next = DIV_P;
                    start_calc = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cfg_valid = (state == COMMIT);

    // Remember presses that arrive while a computation is in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pending <= 1'b0;
        end else if (start_calc) begin
            pending <= 1'b0;
        end else if (any_press && (state != IDLE)) begin
            pending <= 1'b1;
        end
    end

    // Shared divider/multiplier: CLK_HZ/f, then p*duty, then /100.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            duty_snap <= '0;
            p_calc    <= '0;
            h_calc    <= '0;
        end else if (start_calc) begin
            a_reg     <= CLK_HZ_W;
            b_reg     <= {23'd0, freq_next};
            r_reg     <= '0;
            cnt       <= '0;
            duty_snap <= duty_next;
        end else begin
            case (state)
                DIV_P: begin
                    if (cnt == 5'd31) begin
                        p_calc <= div_q[23:0];
                        a_reg  <= {24'd0, duty_snap};
                        b_reg  <= {8'd0, div_q[23:0]};
                        r_reg  <= '0;
                        cnt    <= '0;
                    end else begin
                        a_reg  <= div_q;
                        r_reg  <= div_r;
                        cnt    <= cnt + 5'd1;
                    end
                end
                MUL_H: begin
                    if (cnt == 5'd7) begin
                        a_reg <= mul_acc;
                        b_reg <= 32'd100;
                        r_reg <= '0;
                        cnt   <= '0;
                    end else begin
                        a_reg <= {1'b0, a_reg[31:1]};
                        b_reg <= {b_reg[30:0], 1'b0};
                        r_reg <= mul_acc;
                        cnt   <= cnt + 5'd1;
                    end
                end
                DIV_H: begin
                    if (cnt == 5'd31) begin
                        h_calc <= div_q[23:0];
                        cnt    <= '0;
                    end else begin
                        a_reg  <= div_q;
                        r_reg  <= div_r;
                        cnt    <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Committed pair: both words change together on the period boundary.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            period <= PERIOD_RST;
            htime  <= HTIME_RST;
        end else if (commit_now) begin
            period <= p_calc;
            htime  <= h_calc;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Testbench for pwm_cfg_sequencer: directed steps with randomized spacing,
// expected counts from an arithmetic model of the settings.
module tb_pwm_cfg_sequencer;

    localparam int CLK_HZ = 50_000_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        press_duty = 1'b0;
    logic        press_freq = 1'b0;
    logic        period_end = 1'b0;
    logic [7:0]  duty;
    logic [8:0]  frequency;
    logic [23:0] period;
    logic [23:0] htime;
    logic        cfg_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_cfg = 0;
    int pe_interval = 0;
    int pe_cnt = 0;
    int m_duty = 99;
    int m_freq = 200;
    logic [47:0] exp_q[$];

    bit          mon_armed = 1'b0;
    bit          rst_seen = 1'b1;
    logic [23:0] prev_p;
    logic [23:0] prev_h;

    pwm_cfg_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .press_duty (press_duty),
        .press_freq (press_freq),
        .period_end (period_end),
        .duty       (duty),
        .frequency  (frequency),
        .period     (period),
        .htime      (htime),
        .cfg_valid  (cfg_valid),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {period, htime} for a given frequency/duty, straight arithmetic.
    function automatic logic [47:0] exp_pair(input int f, input int d);
        logic [63:0] p;
        logic [63:0] h;
        p = 64'(CLK_HZ) / 64'(f);
        h = (p * 64'(d)) / 64'd100;
        return {p[23:0], h[23:0]};
    endfunction

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b1;
        repeat (ncyc) tick();
        rst_n = 1'b0;
        m_duty = 99;
        m_freq = 200;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic press(input logic d, input logic f);
        press_duty = d;
        press_freq = f;
        tick();
        press_duty = 1'b0;
        press_freq = 1'b0;
        if (d) m_duty = (m_duty - 2 < 1) ? 99 : m_duty - 2;
        if (f) m_freq = (m_freq - 4 < 4) ? 200 : m_freq - 4;
        check("duty_after_press", 32'(duty), 32'(m_duty));
        check("freq_after_press", 32'(frequency), 32'(m_freq));
        check("busy_after_press", 32'(busy), 32'd1);
    endtask

    // period_end source: one pulse every pe_interval cycles (0 = silent).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pe_interval > 0) begin
                pe_cnt = pe_cnt + 1;
                if (pe_cnt >= pe_interval) pe_cnt = 0;
                period_end = (pe_cnt == 0);
            end else begin
                period_end = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        rst_seen = rst_n;
        if (cfg_valid === 1'b1) n_cfg++;
    end

    // The committed pair may only move in a cfg_valid cycle (or by reset).
    always @(negedge clk) begin
        if (mon_armed && !rst_seen && (period !== prev_p || htime !== prev_h)) begin
            check("cfg_valid_on_change", 32'(cfg_valid), 32'd1);
            check("htime_le_period", 32'(htime <= period), 32'd1);
        end
        prev_p = period;
        prev_h = htime;
    end

    task automatic wait_commit(input string tag, input int budget, output int cyc);
        logic [47:0] e;
        bit seen;
        e = exp_q.pop_front();
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < budget) begin
            tick();
            cyc++;
            if (cfg_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_period"}, 32'(period), 32'(e[47:24]));
            check({tag, "_htime"}, 32'(htime), 32'(e[23:0]));
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [47:0] e;
        int c;
        c = 0;
        while (busy === 1'b1 && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        e = exp_pair(m_freq, m_duty);
        check({tag, "_period"}, 32'(period), 32'(e[47:24]));
        check({tag, "_htime"}, 32'(htime), 32'(e[23:0]));
        check({tag, "_h_le_p"}, 32'(htime <= period), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int n0;
        int nb;
        logic [1:0] sel;

        // Reset state, then idle with no presses.
        apply_reset(3);
        mon_armed = 1'b1;
        check("rst_duty", 32'(duty), 32'd99);
        check("rst_freq", 32'(frequency), 32'd200);
        check("rst_period", 32'(period), 32'd250000);
        check("rst_htime", 32'(htime), 32'd247500);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        repeat (40) tick();
        check("idle_no_cfg", 32'(n_cfg), 32'd0);

        // Single duty press, period_end every 100 cycles.
        pe_interval = 100;
        press(1'b1, 1'b0);
        exp_q.push_back(exp_pair(m_freq, m_duty));
        wait_commit("duty97", 400, cyc);
        check("duty97_lat_min", 32'(cyc >= 73), 32'd1);
        check("duty97_lat_max", 32'(cyc <= 173), 32'd1);
        check("duty97_period_const", 32'(period), 32'd250000);
        check("duty97_htime_const", 32'(htime), 32'd242500);
        tick();
        check("cfg_one_cycle", 32'(cfg_valid), 32'd0);
        check("busy_after_commit", 32'(busy), 32'd0);

        // Single frequency press.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        press(1'b0, 1'b1);
        check("freq196", 32'(frequency), 32'd196);
        exp_q.push_back(exp_pair(m_freq, m_duty));
        wait_commit("freq196", 400, cyc);
        check("freq196_period_abs", 32'(period), 32'd255102);
        check("freq196_htime_abs", 32'(htime), 32'd252550);

        // Frequency walk down to the minimum and wrap.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        for (int i = 0; i < 49; i++) press(1'b0, 1'b1);
        check("freq_min", 32'(frequency), 32'd4);
        wait_idle("freq4", 1000);
        check("freq4_period_abs", 32'(period), 32'd12500000);
        check("freq4_htime_abs", 32'(htime), 32'd12375000);
        press(1'b0, 1'b1);
        check("freq_wrap", 32'(frequency), 32'd200);
        wait_idle("freq_wrap", 1000);

        // Duty walk down to 1 and wrap.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        for (int i = 0; i < 49; i++) press(1'b1, 1'b0);
        check("duty_min", 32'(duty), 32'd1);
        wait_idle("duty1", 1000);
        check("duty1_htime_abs", 32'(htime), 32'd2500);
        press(1'b1, 1'b0);
        check("duty_wrap", 32'(duty), 32'd99);
        wait_idle("duty_wrap", 1000);

        // Second press while busy: exactly two commits, old then new snapshot.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        n0 = n_cfg;
        press(1'b1, 1'b0);
        exp_q.push_back(exp_pair(m_freq, m_duty));
        repeat (9) tick();
        press(1'b1, 1'b0);
        exp_q.push_back(exp_pair(m_freq, m_duty));
        wait_commit("pend_first", 400, cyc);
        check("pend_first_h_abs", 32'(htime), 32'd242500);
        wait_commit("pend_second", 400, cyc);
        check("pend_second_h_abs", 32'(htime), 32'd237500);
        wait_idle("pend", 400);
        repeat (200) tick();
        check("pend_two_commits", 32'(n_cfg - n0), 32'd2);

        // Both keys in the same cycle: one recompute.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        n0 = n_cfg;
        press(1'b1, 1'b1);
        check("both_duty", 32'(duty), 32'd97);
        check("both_freq", 32'(frequency), 32'd196);
        exp_q.push_back(exp_pair(m_freq, m_duty));
        wait_commit("both", 400, cyc);
        check("both_period_abs", 32'(period), 32'd255102);
        check("both_htime_abs", 32'(htime), 32'd247448);
        repeat (200) tick();
        check("both_one_commit", 32'(n_cfg - n0), 32'd1);

        // Reset during the high-time divide; a press during reset is ignored.
        apply_reset(2);
        pe_interval = $urandom_range(10, 150);
        press(1'b1, 1'b0);
        repeat (49) tick();
        n0 = n_cfg;
        rst_n = 1'b1;
        press_duty = 1'b1;
        tick();
        rst_n = 1'b0;
        press_duty = 1'b0;
        m_duty = 99;
        m_freq = 200;
        check("mid_rst_duty", 32'(duty), 32'd99);
        check("mid_rst_freq", 32'(frequency), 32'd200);
        check("mid_rst_period", 32'(period), 32'd250000);
        check("mid_rst_htime", 32'(htime), 32'd247500);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cfg_valid", 32'(cfg_valid), 32'd0);
        repeat (200) tick();
        check("mid_rst_no_commit", 32'(n_cfg - n0), 32'd0);

        // Random bursts of presses; final committed pair must match final settings.
        apply_reset(2);
        for (int b = 0; b < 6; b++) begin
            pe_interval = $urandom_range(5, 150);
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                sel = 2'($urandom_range(1, 3));
                press(sel[0], sel[1]);
                repeat ($urandom_range(0, 30)) tick();
            end
            wait_idle("rand", 1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Owns the user-adjustable PWM settings: duty in percent and frequency in Hz.
- Steps them on debounced key-press pulses.
- Computes the generator's period and high-time counts with a shared multi-cycle divider/multiplier instead of combinational arithmetic.
- Commits new values to the PWM generator only on a PWM period boundary. Sits between the key filters and the LED PWM generator; also feeds the 7-segment display.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; period = CLK_HZ / frequency.
- DUTY_INIT, 99, duty after reset and on wrap.
- DUTY_STEP, 2, duty decrement per press.
- FREQ_INIT, 200, frequency after reset and on wrap.
- FREQ_STEP, 4, frequency decrement per press.
- FREQ_MIN, 4, lowest legal frequency.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (1 = reset; name kept per codebase convention)
- press_duty  in  1  one-cycle pulse from duty key filter
- press_freq  in  1  one-cycle pulse from frequency key filter
- period_end  in  1  one-cycle pulse from PWM generator on last count of current period
- duty  out  8  current duty setting, percent
- frequency  out  9  current frequency setting, Hz
- period  out  24  committed period count to generator
- htime  out  24  committed high-time count to generator
- cfg_valid  out  1  one-cycle pulse in the cycle period/htime change
- busy  out  1  high while computing or awaiting commit

Behaviour:
- Reset values:
  - duty = DUTY_INIT; frequency = FREQ_INIT.
  - period = CLK_HZ/FREQ_INIT (250000); htime = period*DUTY_INIT/100 (247500). Both come from elaboration-time constants.
  - cfg_valid = 0, busy = 0, FSM = IDLE, pending = 0.
- Settings update on the press cycle edge, independent of FSM state:
  - duty: if duty < DUTY_STEP + 1, load DUTY_INIT; else duty − DUTY_STEP. Sequence 99, 97, …, 3, 1, 99.
  - frequency: if frequency − FREQ_STEP < FREQ_MIN, load FREQ_INIT; else frequency − FREQ_STEP. Sequence 200, 196, …, 4, 200.
  - Both presses in the same cycle: both update, one recompute.
- FSM states: IDLE, DIV_P, MUL_H, DIV_H, WAIT_EDGE, COMMIT.
  - IDLE: on any press → DIV_P. Snapshot duty/frequency as updated by that press.
  - DIV_P: 32-bit restoring divide, CLK_HZ / freq_snap, 1 quotient bit per cycle, exactly 32 cycles. Quotient truncated to 24 bits → p_calc.
  - MUL_H: shift-add p_calc * duty_snap, 8 cycles, 32-bit product.
  - DIV_H: product / 100 via the same divider, 32 cycles, truncated → h_calc. Remainder is discarded (floor).
  - WAIT_EDGE: hold until period_end = 1. If period_end is high on the first WAIT_EDGE cycle, that counts.
  - COMMIT: period ← p_calc, htime ← h_calc, cfg_valid = 1 for this cycle. Then → DIV_P if pending, else IDLE, clearing pending.
- busy = 1 in every state except IDLE. Press-to-WAIT_EDGE latency is 72 cycles.
- Press while not IDLE:
  - Sets pending; the in-flight computation continues with its old snapshot and still commits.
  - The recompute then uses the current settings.
  - Multiple presses collapse into one recompute.
- The divider and multiplier are a single shared datapath; there is only one operation at a time.
- period/htime never change outside COMMIT. Generator never sees a half-updated pair; htime ≤ period always.
- Reset mid-computation: aborts immediately and restores all reset values. A pulse arriving with reset high is ignored.
- Width guarantees:
  - frequency ≥ 4 means period ≤ 12_500_000, which fits 24 bits.
  - The product ≤ 12.5M*99, which fits 32 bits.

Test Plan:
- Release reset, no presses → period=250000, htime=247500, duty=99, frequency=200, busy=0, cfg_valid never pulses.
- One press_duty, period_end pulsing every 100 cycles:
  - duty=97 next cycle, busy next cycle.
  - On the first period_end at least 72 cycles after the press: cfg_valid pulses one cycle later, htime=242500, period unchanged.
- One press_freq → frequency=196. Commit gives period=255102, htime=252550.
- 50 press_freq pulses: frequency reaches 4 (period 12500000, htime 12375000); 50th press wraps to 200. Similarly, 50 duty presses take duty to 1; the 50th wraps to 99.
- Second press_duty 10 cycles after the first (busy) → exactly two cfg_valid pulses. The first commits htime for duty 97, the second for duty 95 (237500).
- Simultaneous press_duty+press_freq → single commit with frequency=196, duty=97, period=255102, htime=247448.
- Assert rst_n for 1 cycle during DIV_H → all outputs return to reset values, no cfg_valid, busy=0 the cycle after.
